// File: rtl/overlay_pkg.sv
// overlay_pkg: overlay word field positions, FSM states and a saturating counter helper.
package overlay_pkg;
  localparam int OVL_W       = 54;
  localparam int OVL_MASK_HI = 53;
  localparam int OVL_MASK_LO = 50;
  localparam int OVL_FRAME   = 49;
  localparam int OVL_ADDR_HI = 48;
  localparam int OVL_ADDR_LO = 32;
  localparam int OVL_PIX_HI  = 31;
  localparam logic [16:0] CNT_MAX = 17'h1FFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLOSE} state_t;
  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == CNT_MAX) ? v : v + 17'd1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered full/empty derived from a registered count.
module sync_fifo
  import overlay_pkg::*;
#(
  parameter int WIDTH = OVL_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count, w_next;
  logic r_full, r_empty, w_push, w_pop;
  assign w_push = push & ~r_full;
  assign w_pop  = pop & ~r_empty;
  assign w_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign head   = r_mem[r_rptr];
  assign full   = r_full;
  assign empty  = r_empty;
  always_ff @(posedge clock) if (w_push) r_mem[r_wptr] <= din;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= w_next;
      r_full  <= w_next == (AW+1)'(DEPTH);
      r_empty <= w_next == '0;
    end
  end
endmodule

// File: rtl/overlay_fb_writer.sv
// overlay_fb_writer: buffers overlay words and turns them into byte-masked framebuffer writes,
// closing a frame on a frame-bit change or on flush with a frame_done/ack handshake.
module overlay_fb_writer
  import overlay_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               FB_AW    = 28,
  parameter logic [FB_AW-1:0] FB0_BASE = 28'h0010000,
  parameter logic [FB_AW-1:0] FB1_BASE = 28'h0030000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OVL_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [FB_AW-1:0] wr_addr,
  output logic [31:0]      wr_data,
  output logic [3:0]       wr_mask,
  output logic             frame_done,
  input  logic             frame_done_ack,
  output logic             frame_done_id,
  output logic [16:0]      write_count,
  output logic [16:0]      drop_count
);
  logic [OVL_W-1:0] w_head;
  logic w_full, w_empty, w_push, w_pop, w_frame;
  logic [3:0] w_mask;
  logic [FB_AW-1:0] w_addr;
  state_t r_state;
  logic r_wr_valid, r_done, r_done_id, r_cur_frame, r_next_frame;
  logic [FB_AW-1:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [3:0] r_wr_mask;
  logic [16:0] r_wc, r_dc;
  assign din_ready = ~w_full & ~reset;
  assign w_push    = din_valid & din_ready;
  assign w_mask    = w_head[OVL_MASK_HI:OVL_MASK_LO];
  assign w_frame   = w_head[OVL_FRAME];
  assign w_addr    = (w_frame ? FB1_BASE : FB0_BASE) + FB_AW'({w_head[OVL_ADDR_HI:OVL_ADDR_LO], 2'b00});
  assign w_pop     = (r_state == ST_IDLE) & ~w_empty & (w_frame == r_cur_frame);
  sync_fifo #(.WIDTH(OVL_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(w_push), .din(din), .pop(w_pop),
    .head(w_head), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_mask    <= '0;
      r_done       <= 1'b0;
      r_done_id    <= 1'b0;
      r_cur_frame  <= 1'b1;
      r_next_frame <= 1'b1;
      r_wc         <= '0;
      r_dc         <= '0;
    end else begin
      if (r_done & frame_done_ack) r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && w_frame != r_cur_frame) begin
            r_state      <= ST_CLOSE;
            r_next_frame <= w_frame;
          end else if (w_pop && w_mask != 4'd0) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= w_addr;
            r_wr_data  <= w_head[OVL_PIX_HI:0];
            r_wr_mask  <= w_mask;
            r_state    <= ST_WRITE;
          end else if (w_pop) begin
            r_dc <= sat_inc(r_dc);
          end else if (w_empty && flush && (r_wc != '0 || r_dc != '0)) begin
            r_state      <= ST_CLOSE;
            r_next_frame <= r_cur_frame;
          end
        end
        ST_WRITE: if (wr_ready) begin
          r_wr_valid <= 1'b0;
          r_wc       <= sat_inc(r_wc);
          r_state    <= ST_IDLE;
        end
        ST_CLOSE: if (!r_done) begin
          // a previous frame still awaiting its ack holds us here
          r_done      <= 1'b1;
          r_done_id   <= r_cur_frame;
          r_wc        <= '0;
          r_dc        <= '0;
          r_cur_frame <= r_next_frame;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign wr_valid      = r_wr_valid;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign wr_mask       = r_wr_mask;
  assign frame_done    = r_done;
  assign frame_done_id = r_done_id;
  assign write_count   = r_wc;
  assign drop_count    = r_dc;
endmodule

// File: tb/tb_overlay_fb_writer.sv
// tb_overlay_fb_writer: directed scenarios plus random traffic against a word-level reference model.
module tb_overlay_fb_writer;
  logic clock = 1'b0;
  logic reset, din_valid, flush, wr_ready, frame_done_ack;
  logic [53:0] din;
  logic din_ready, wr_valid, frame_done, frame_done_id;
  logic [27:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_mask;
  logic [16:0] write_count, drop_count;
  int checks = 0, errors = 0;
  int rdy_pct = 100;
  bit ack_en = 1'b1;
  bit prev_done = 1'b0;
  typedef struct { logic [27:0] a; logic [31:0] d; logic [3:0] m; } wr_t;
  wr_t exp_wr[$];
  bit exp_close[$];
  bit m_cur = 1'b1;
  int m_wc = 0, m_dc = 0;

  overlay_fb_writer dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .frame_done(frame_done),
    .frame_done_ack(frame_done_ack), .frame_done_id(frame_done_id),
    .write_count(write_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] mk(input logic [3:0] m, input bit f, input logic [16:0] a, input logic [31:0] p);
    return {m, f, a, p};
  endfunction

  // frame semantics: a frame-bit change closes the current frame before the new word counts
  function automatic void model_accept(input logic [53:0] w);
    wr_t e;
    if (w[49] != m_cur) begin
      exp_close.push_back(m_cur);
      m_cur = w[49];
      m_wc = 0;
      m_dc = 0;
    end
    if (w[53:50] != 4'd0) begin
      e.a = (w[49] ? 28'h0030000 : 28'h0010000) + 28'(w[48:32]) * 28'd4;
      e.d = w[31:0];
      e.m = w[53:50];
      exp_wr.push_back(e);
      m_wc++;
    end else m_dc++;
  endfunction

  function automatic void model_reset();
    exp_wr.delete();
    exp_close.delete();
    m_cur = 1'b1;
    m_wc = 0;
    m_dc = 0;
  endfunction

  always @(posedge clock) begin
    #1;
    wr_ready = ($urandom_range(0, 99) < rdy_pct);
    frame_done_ack = ack_en && ($urandom_range(0, 3) == 0);
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_valid) begin
        if (exp_wr.size() == 0) chk("unexp_wr", wr_valid, 0);
        else begin
          chk("wr_addr", wr_addr, exp_wr[0].a);
          chk("wr_data", wr_data, exp_wr[0].d);
          chk("wr_mask", wr_mask, exp_wr[0].m);
          if (wr_ready) void'(exp_wr.pop_front());
        end
      end
      if (frame_done && !prev_done) begin
        if (exp_close.size() == 0) chk("unexp_done", frame_done, 0);
        else begin
          chk("done_id", frame_done_id, exp_close.pop_front());
          chk("cnt_clr", {write_count, drop_count}, 0);
        end
      end
      prev_done = frame_done;
    end else prev_done = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rdy(input int p);
    rdy_pct = p;
    tick(1);
  endtask

  task automatic push(input logic [53:0] w);
    int n = 0;
    logic acc;
    din = w;
    din_valid = 1'b1;
    do begin
      @(negedge clock);
      acc = din_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 200);
    din_valid = 1'b0;
    if (acc) model_accept(w);
    else chk("push_to", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_close.size() != 0) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("drain", exp_wr.size() + exp_close.size(), 0);
    tick(4);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_wc"}, write_count, m_wc);
    chk({tag, "_dc"}, drop_count, m_dc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wrv"}, wr_valid, 0);
    chk({tag, "_wr"}, {wr_addr, wr_data, wr_mask}, 0);
    chk({tag, "_done"}, {frame_done, frame_done_id}, 0);
    chk({tag, "_cnt"}, {write_count, drop_count}, 0);
  endtask

  initial begin
    int n;
    bit f;
    reset = 1'b1; din_valid = 1'b0; din = '0; flush = 1'b0;
    wr_ready = 1'b1; frame_done_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", din_ready, 0);
    chk_reset_vals("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", din_ready, 1);
    tick(1);
    for (int i = 0; i < 3; i++) push(mk(4'hF, 1'b1, 17'(i), $urandom));
    drain();
    chk_counts("t1");
    chk("t1_wc3", write_count, 3);
    push(mk(4'h5, 1'b1, 17'd10, $urandom));
    push(mk(4'h0, 1'b1, 17'd11, $urandom));
    push(mk(4'h5, 1'b1, 17'd12, $urandom));
    drain();
    chk_counts("t2");
    chk("t2_dc1", drop_count, 1);
    set_rdy(0);
    for (int i = 0; i < 5; i++) push(mk(4'($urandom_range(1, 15)), 1'b1, 17'($urandom), $urandom));
    @(negedge clock);
    chk("full_ready", din_ready, 0);
    tick(10);
    chk("stall_valid", wr_valid, 1);
    set_rdy(100);
    drain();
    chk_counts("t3");
    push(mk(4'hF, 1'b1, 17'd20, $urandom));
    push(mk(4'hF, 1'b1, 17'd21, $urandom));
    push(mk(4'hF, 1'b0, 17'd7, $urandom));
    drain();
    chk_counts("t4");
    n = 0;
    while (frame_done && n < 200) begin tick(1); n++; end
    chk("t5_ackwait", frame_done, 0);
    ack_en = 1'b0;
    tick(2);
    push(mk(4'hF, 1'b1, 17'd30, $urandom));
    push(mk(4'hF, 1'b0, 17'd31, $urandom));
    tick(20);
    @(negedge clock);
    chk("t5_done", frame_done, 1);
    chk("t5_id", frame_done_id, 0);
    chk("t5_pend", exp_close.size(), 1);
    chk("t5_wrpend", exp_wr.size(), 1);
    ack_en = 1'b1;
    drain();
    chk_counts("t5");
    set_rdy(0);
    for (int i = 0; i < 4; i++) push(mk(4'hF, m_cur, 17'(40 + i), $urandom));
    @(negedge clock);
    chk("t6_valid", wr_valid, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    chk("t6_rst_ready", din_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("t6");
    chk("t6_ready", din_ready, 1);
    set_rdy(100);
    tick(20);
    rdy_pct = 70;
    f = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) f = ~f;
      push(mk(($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), f, 17'($urandom), $urandom));
      tick($urandom_range(0, 2));
    end
    drain();
    chk_counts("rand");
    flush = 1'b1;
    if (m_wc + m_dc != 0) begin
      exp_close.push_back(m_cur);
      m_wc = 0;
      m_dc = 0;
    end
    drain();
    flush = 1'b0;
    chk_counts("flush");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
